// File: rtl/pipe_dbg_pkg.sv
// Shared debug-control types for the MIPS pipeline: run states, host command
// codes and the halt opcode recognised by fetch/decode/writeback.
package pipe_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_DONE = 2'b11
   } run_state_t;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_STEP = 2'b10,
      CMD_STOP = 2'b11
   } cmd_code_t;

   localparam logic [5:0] HALT_OPCODE = 6'b111111;
   localparam int         STEP_W      = 8;
   localparam int         COUNT_W     = 32;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones; async active-low clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] count
);

   logic at_max;

   assign at_max = (count == {W{1'b1}});

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count <= '0;
      end else if (en && !at_max) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Debug run controller: owns the pipeline-wide debug stall, executes host
// RUN/STEP/STOP commands, stops on retired halt or cycle watchdog.
module pipeline_run_ctrl
   import pipe_dbg_pkg::*;
#(
   parameter int          STEP_CYCLES = 1,
   parameter logic [31:0] MAX_CYCLES  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_code,
   output logic        cmd_ready,
   input  logic        halt_seen,
   output logic        stall_db,
   output logic [1:0]  state,
   output logic [31:0] cycle_count,
   output logic        done_pulse,
   output logic        timeout
);

   run_state_t         state_q;
   run_state_t         state_next;
   logic [STEP_W-1:0]  step_q;
   logic [STEP_W-1:0]  step_next;
   logic               timeout_set;
   logic               timeout_clr;
   logic               cmd_fire;
   cmd_code_t          cmd;
   logic               wd_hit;
   logic [COUNT_W:0]   count_plus1;

   assign cmd       = cmd_code_t'(cmd_code);
   assign cmd_ready = (state_q != ST_STEP);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign state     = state_q;

   // Widened by one bit so the +1 compare cannot wrap at the top of the range.
   assign count_plus1 = {1'b0, cycle_count} + (COUNT_W+1)'(1);
   assign wd_hit      = (MAX_CYCLES != 32'd0) && !stall_db &&
                        (count_plus1 == {1'b0, MAX_CYCLES});

   sat_counter #(
      .W (COUNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .en    (!stall_db),
      .count (cycle_count)
   );

   always_comb begin
      state_next  = state_q;
      step_next   = step_q;
      timeout_set = 1'b0;
      timeout_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire && cmd == CMD_RUN) begin
               state_next = ST_RUN;
            end else if (cmd_fire && cmd == CMD_STEP) begin
               step_next  = STEP_W'(STEP_CYCLES);
               state_next = ST_STEP;
            end
         end
         // Halt outranks both the watchdog and a concurrent STOP.
         ST_RUN: begin
            if (halt_seen) begin
               state_next = ST_DONE;
            end else if (wd_hit) begin
               state_next  = ST_DONE;
               timeout_set = 1'b1;
            end else if (cmd_fire && cmd == CMD_STOP) begin
               state_next = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (halt_seen) begin
               state_next = ST_DONE;
            end else begin
               step_next = (step_q != '0) ? step_q - STEP_W'(1) : step_q;
               if (step_q <= STEP_W'(1)) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            if (cmd_fire && cmd == CMD_STOP) begin
               state_next  = ST_IDLE;
               timeout_clr = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // stall_db is registered from the next state so it never sees inputs combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         stall_db   <= 1'b1;
         done_pulse <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_next;
         step_q     <= step_next;
         stall_db   <= (state_next == ST_IDLE) || (state_next == ST_DONE);
         done_pulse <= (state_next == ST_DONE) && (state_q != ST_DONE);
         if (timeout_set) begin
            timeout <= 1'b1;
         end else if (timeout_clr) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with STEP_CYCLES=3, MAX_CYCLES=50.
module tb_pipeline_run_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [1:0]  cmd_code;
   logic        cmd_ready;
   logic        halt_seen;
   logic        stall_db;
   logic [1:0]  state;
   logic [31:0] cycle_count;
   logic        done_pulse;
   logic        timeout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_DONE = 2'b11;
   localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_STOP = 2'b11;

   pipeline_run_ctrl #(
      .STEP_CYCLES (3),
      .MAX_CYCLES  (32'd50)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_ready   (cmd_ready),
      .halt_seen   (halt_seen),
      .stall_db    (stall_db),
      .state       (state),
      .cycle_count (cycle_count),
      .done_pulse  (done_pulse),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] code);
      cmd_valid = 1'b1;
      cmd_code  = code;
      tick();
      cmd_valid = 1'b0;
      cmd_code  = C_NOP;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      cmd_code  = C_NOP;
      halt_seen = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if ({stall_db, state, cmd_ready, done_pulse, timeout} !== {1'b1, S_IDLE, 1'b1, 1'b0, 1'b0}
             || cycle_count !== 32'd0) begin
            $display("FAIL reset_idle cyc%0d: stall=%b state=%b ready=%b dp=%b to=%b cnt=%0d, want 1 00 1 0 0 0",
                     i, stall_db, state, cmd_ready, done_pulse, timeout, cycle_count);
         end else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_step();
      int lows;
      do_reset();
      send_cmd(C_STEP);
      total_cnt++;
      if (state !== S_STEP) $display("FAIL step_state: got %b want %b", state, S_STEP);
      else pass_cnt++;
      lows = 0;
      while (stall_db === 1'b0 && lows < 10) begin
         total_cnt++;
         if (cmd_ready !== 1'b0) $display("FAIL step_ready cyc%0d: got %b want 0", lows, cmd_ready);
         else pass_cnt++;
         lows++;
         tick();
      end
      total_cnt++;
      if (lows !== 3) $display("FAIL step_low_cycles: got %0d want 3", lows);
      else pass_cnt++;
      total_cnt++;
      if (state !== S_IDLE || cycle_count !== 32'd3)
         $display("FAIL step_end: state=%b cnt=%0d want 00 3", state, cycle_count);
      else pass_cnt++;
   endtask

   task automatic test_run_halt();
      do_reset();
      send_cmd(C_RUN);
      total_cnt++;
      if (state !== S_RUN || stall_db !== 1'b0 || cycle_count !== 32'd0)
         $display("FAIL run_start: state=%b stall=%b cnt=%0d want 01 0 0", state, stall_db, cycle_count);
      else pass_cnt++;
      repeat (19) tick();
      halt_seen = 1'b1;
      tick();
      halt_seen = 1'b0;
      total_cnt++;
      if ({state, stall_db, done_pulse, timeout} !== {S_DONE, 1'b1, 1'b1, 1'b0} || cycle_count !== 32'd20)
         $display("FAIL halt_done: state=%b stall=%b dp=%b to=%b cnt=%0d want 11 1 1 0 20",
                  state, stall_db, done_pulse, timeout, cycle_count);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done_pulse !== 1'b0 || cycle_count !== 32'd20)
         $display("FAIL halt_hold: dp=%b cnt=%0d want 0 20", done_pulse, cycle_count);
      else pass_cnt++;
      send_cmd(C_RUN);
      total_cnt++;
      if (state !== S_DONE || stall_db !== 1'b1 || cycle_count !== 32'd20)
         $display("FAIL done_run_ignored: state=%b stall=%b cnt=%0d want 11 1 20", state, stall_db, cycle_count);
      else pass_cnt++;
      send_cmd(C_STOP);
      total_cnt++;
      if (state !== S_IDLE || stall_db !== 1'b1)
         $display("FAIL done_stop: state=%b stall=%b want 00 1", state, stall_db);
      else pass_cnt++;
   endtask

   task automatic test_watchdog();
      int n;
      do_reset();
      send_cmd(C_RUN);
      n = 0;
      while (state !== S_DONE && n < 100) begin
         tick();
         n++;
      end
      total_cnt++;
      if (n !== 50 || cycle_count !== 32'd50)
         $display("FAIL wd_cycles: ticks=%0d cnt=%0d want 50 50", n, cycle_count);
      else pass_cnt++;
      total_cnt++;
      if (timeout !== 1'b1 || done_pulse !== 1'b1 || stall_db !== 1'b1)
         $display("FAIL wd_flags: to=%b dp=%b stall=%b want 1 1 1", timeout, done_pulse, stall_db);
      else pass_cnt++;
      repeat (3) tick();
      total_cnt++;
      if (cycle_count !== 32'd50 || timeout !== 1'b1)
         $display("FAIL wd_hold: cnt=%0d to=%b want 50 1", cycle_count, timeout);
      else pass_cnt++;
      send_cmd(C_STOP);
      total_cnt++;
      if (timeout !== 1'b0 || state !== S_IDLE)
         $display("FAIL wd_stop_clear: to=%b state=%b want 0 00", timeout, state);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      send_cmd(C_RUN);
      repeat (4) tick();
      cmd_valid = 1'b1;
      cmd_code  = C_STOP;
      halt_seen = 1'b1;
      tick();
      cmd_valid = 1'b0;
      halt_seen = 1'b0;
      total_cnt++;
      if (state !== S_DONE || timeout !== 1'b0 || cycle_count !== 32'd5)
         $display("FAIL stop_halt: state=%b to=%b cnt=%0d want 11 0 5", state, timeout, cycle_count);
      else pass_cnt++;
      // Halt arriving on the same edge as the watchdog hit.
      do_reset();
      send_cmd(C_RUN);
      repeat (49) tick();
      halt_seen = 1'b1;
      tick();
      halt_seen = 1'b0;
      total_cnt++;
      if (state !== S_DONE || timeout !== 1'b0 || cycle_count !== 32'd50)
         $display("FAIL halt_wd: state=%b to=%b cnt=%0d want 11 0 50", state, timeout, cycle_count);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      send_cmd(C_STEP);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (stall_db !== 1'b1 || cycle_count !== 32'd0 || state !== S_IDLE)
         $display("FAIL async_reset: stall=%b cnt=%0d state=%b want 1 0 00", stall_db, cycle_count, state);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (stall_db !== 1'b1 || cycle_count !== 32'd0)
         $display("FAIL async_reset_hold: stall=%b cnt=%0d want 1 0", stall_db, cycle_count);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (stall_db !== 1'b1 || cycle_count !== 32'd0 || state !== S_IDLE)
         $display("FAIL async_release: stall=%b cnt=%0d state=%b want 1 0 00", stall_db, cycle_count, state);
      else pass_cnt++;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_code  = C_NOP;
      halt_seen = 1'b0;
      test_reset();
      test_step();
      test_run_halt();
      test_watchdog();
      test_simultaneous();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Debug run controller for the MIPS pipeline. It owns the debug stall line that freezes the fetch stage (PC update and instruction output) and the downstream stages. It accepts run, step and stop commands from the debug host over a valid/ready handshake. It stops the pipeline when the halt opcode retires or when a cycle watchdog expires, and it reports execution status and a count of executed cycles.

## Interface
- `STEP_CYCLES`, default 1: unstalled cycles per STEP command; legal range 1..255.
- `MAX_CYCLES`, default 32'hFFFF_FFFF: watchdog limit on `cycle_count` in RUN; 0 disables the watchdog.
- `clk` in 1: single clock for the pipeline and this controller.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command valid.
- `cmd_code` in 2: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
- `cmd_ready` out 1: command accepted on a clock edge where `cmd_valid && cmd_ready`.
- `halt_seen` in 1: one-cycle pulse from writeback when the halt opcode (all-ones opcode field) retires.
- `stall_db` out 1: debug stall to fetch and all stages; 1 = frozen.
- `state` out 2: 00 IDLE, 01 RUN, 10 STEP, 11 DONE.
- `cycle_count` out 32: number of cycles with `stall_db` = 0 since reset; saturating.
- `done_pulse` out 1: high for one cycle on entry to DONE.
- `timeout` out 1: sticky; set when DONE is entered through the watchdog.

## Operation
- **IDLE**
  - RUN goes to RUN.
  - STEP loads the step counter with `STEP_CYCLES` and goes to STEP.
  - STOP and NOP are consumed with no effect.
- **RUN**
  - STOP goes to IDLE.
  - RUN, STEP and NOP are consumed with no effect.
  - `halt_seen` goes to DONE.
  - Watchdog: if `MAX_CYCLES` ≠ 0 and `cycle_count` + 1 == `MAX_CYCLES` on an unstalled cycle, go to DONE and set `timeout`.
- **STEP**
  - `cmd_ready` = 0.
  - The step counter decrements on each unstalled cycle. When it reaches 0, go to IDLE.
  - `halt_seen` goes to DONE.
- **DONE**
  - `stall_db` = 1.
  - STOP goes to IDLE and clears `timeout`.
  - RUN, STEP and NOP are consumed with no effect.
  - `cycle_count` holds its value.
- **Signal definitions**
  - `cmd_ready` = 1 in IDLE, RUN and DONE; 0 in STEP.
  - `stall_db` = 1 in IDLE and DONE; 0 in RUN and STEP. It is registered and derived from the next state.
- **Simultaneous events:** `halt_seen` takes priority over an accepted STOP, and over a watchdog hit in the same cycle. In that case DONE is entered with `timeout` = 0.
- **Counter arithmetic:** `cycle_count` saturates at 32'hFFFF_FFFF. The step counter is 8 bits wide.
- **Reset values:** state IDLE, `stall_db` 1, `cmd_ready` 1, `cycle_count` 0, `done_pulse` 0, `timeout` 0, step counter 0.
- **Reset mid-operation:** takes effect immediately, independent of the clock. The pipeline is frozen from assertion onward.

## Timing
- **Command acceptance:** a command accepted at edge N changes `state` and `stall_db` after edge N. For RUN or STEP, the pipeline first advances at edge N+1.
- **STEP of K:** `stall_db` is low for exactly K consecutive cycles, then high. `cycle_count` increases by exactly K.
- **Halt:** `halt_seen` at edge N puts `stall_db` = 1 after edge N. The cycle in which `halt_seen` is high is counted.
- **`done_pulse`:** high in the first cycle `state` reads DONE.
- **No combinational paths** from inputs to `stall_db`. `cmd_ready` is a decode of registered state only.

## Structure
- Package `pipe_dbg_pkg` holds:
  - the state enum (IDLE/RUN/STEP/DONE);
  - the command codes (NOP/RUN/STEP/STOP);
  - the halt opcode constant 6'b111111 shared with the fetch and decode stages.
- One sub-module, `sat_counter`: a parameterised-width, enable-driven, saturating up-counter with asynchronous clear, used for `cycle_count`.
- The FSM and the step down-counter stay in the top module.

## Test plan
- **Reset, then idle:** after `rst_n` release, `stall_db` = 1, `state` = 00, `cmd_ready` = 1, `cycle_count` = 0, and all stay put for 10 cycles.
- **STEP with `STEP_CYCLES` = 3:** STEP accepted → `stall_db` low exactly 3 cycles, `cmd_ready` = 0 throughout, back to IDLE, `cycle_count` = 3.
- **RUN then `halt_seen`:** RUN, then `halt_seen` on the 20th unstalled cycle → `state` DONE, `done_pulse` for one cycle, `cycle_count` = 20, `timeout` = 0. A following RUN has no effect; STOP → IDLE.
- **Watchdog with `MAX_CYCLES` = 50:** RUN with no halt → DONE after 50 unstalled cycles, `timeout` = 1, `cycle_count` = 50. STOP clears `timeout`.
- **Simultaneous STOP and `halt_seen` in RUN:** → DONE, not IDLE.
- **Async reset mid-STEP:** `rst_n` low between edges → `stall_db` = 1 and `cycle_count` = 0 immediately; no further advance.
